ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 196 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clock out
// 8 data bits + odd parity + stop on device clock falls, then check the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [2:0] fsm_state
);

  localparam int PHASE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RTS       = 3'd2,
    S_SEND      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t             state, state_n;
  logic [PHASE_W-1:0] phase_cnt, phase_n;
  logic [TO_W-1:0]    to_cnt, to_n;
  logic [3:0]         bit_cnt, bit_n;
  logic [7:0]         data_q, data_n;
  logic               parity_q, parity_n;
  logic               clk_oe_q, clk_oe_n;
  logic               dat_oe_q, dat_oe_n;
  logic               done_q, done_n;
  logic               error_q, error_n;
  logic               clk_s1, clk_s2, clk_d;
  logic               dat_s1, dat_s2;
  logic               clk_fall;
  logic               in_frame;
  logic               timeout_hit;

  // tx_valid/tx_ready: a byte transfers on any cycle where both are 1; tx_data
  // is captured on that edge and held until the transfer ends.
  assign tx_ready   = (state == S_IDLE);
  assign busy       = ~tx_ready;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_done    = done_q;
  assign tx_error   = error_q;
  assign fsm_state  = state;

  assign clk_fall    = clk_d & ~clk_s2;
  assign in_frame    = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);
  assign timeout_hit = in_frame && !clk_fall && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n  = state;
    phase_n  = phase_cnt;
    to_n     = to_cnt;
    bit_n    = bit_cnt;
    data_n   = data_q;
    parity_n = parity_q;
    clk_oe_n = clk_oe_q;
    dat_oe_n = dat_oe_q;
    done_n   = 1'b0;
    error_n  = 1'b0;

    if (in_frame) begin
      to_n = clk_fall ? '0 : to_cnt + TO_W'(1);
    end

    case (state)
      S_IDLE: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        if (tx_valid) begin
          data_n   = tx_data;
          parity_n = ~^tx_data;
          phase_n  = '0;
          clk_oe_n = 1'b1;
          state_n  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (phase_cnt == PHASE_W'(INHIBIT_CYCLES - 1)) begin
          phase_n  = '0;
          dat_oe_n = 1'b1;
          state_n  = S_RTS;
        end else begin
          phase_n = phase_cnt + PHASE_W'(1);
        end
      end
      S_RTS: begin
        if (phase_cnt == PHASE_W'(SETUP_CYCLES - 1)) begin
          clk_oe_n = 1'b0;
          bit_n    = '0;
          to_n     = '0;
          state_n  = S_SEND;
        end else begin
          phase_n = phase_cnt + PHASE_W'(1);
        end
      end
      S_SEND: begin
        // bit_cnt holds the number of falls already seen, so it indexes the next data bit
        if (clk_fall) begin
          bit_n = bit_cnt + 4'd1;
          if (bit_cnt < 4'd8) begin
            dat_oe_n = ~data_q[bit_cnt[2:0]];
          end else if (bit_cnt == 4'd8) begin
            dat_oe_n = ~parity_q;
          end else begin
            dat_oe_n = 1'b0;
            state_n  = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (clk_fall) begin
          if (dat_s2) begin
            error_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s2 && dat_s2) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        state_n  = S_IDLE;
      end
    endcase

    // a stalled device wins over anything else decided this cycle
    if (timeout_hit) begin
      clk_oe_n = 1'b0;
      dat_oe_n = 1'b0;
      done_n   = 1'b0;
      error_n  = 1'b1;
      state_n  = S_IDLE;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      to_cnt    <= '0;
      bit_cnt   <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      clk_d     <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
    end else begin
      state     <= state_n;
      phase_cnt <= phase_n;
      to_cnt    <= to_n;
      bit_cnt   <= bit_n;
      data_q    <= data_n;
      parity_q  <= parity_n;
      clk_oe_q  <= clk_oe_n;
      dat_oe_q  <= dat_oe_n;
      done_q    <= done_n;
      error_q   <= error_n;
      clk_s1    <= ps2_clk_in;
      clk_s2    <= clk_s1;
      clk_d     <= clk_s2;
      dat_s1    <= ps2_dat_in;
      dat_s2    <= dat_s1;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model clocks frames out of the
// host, collects the line levels and compares them with a frame model.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int STP  = 8;
  localparam int TMO  = 300;
  localparam int HALF = 10;

  localparam int M_ACK     = 0;
  localparam int M_NACK    = 1;
  localparam int M_TIMEOUT = 2;
  localparam int M_RESET   = 3;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_error;
  logic [2:0] fsm_state;
  logic       dev_clk;
  logic       dev_dat;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int end_cyc  = 0;
  logic [1:0] end_oe    = 2'b00;
  logic       end_ready = 1'b0;
  bit         overlap   = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         mode;
    logic [9:0] line;
    bit         done;
    bit         err;
  } vec_t;

  vec_t vecs[6];
  logic [9:0] exp_q[$];

  // open-drain wired-AND of host and device on both lines
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (STP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor
  always @(negedge clk) begin
    if (tx_done && tx_error) overlap = 1'b1;
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done || tx_error) begin
      end_cyc   = cyc;
      end_oe    = {ps2_clk_oe, ps2_dat_oe};
      end_ready = tx_ready;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish, want finish before 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // line levels seen after falls 1..10: data LSB first, odd parity, stop
  function automatic logic [9:0] frame_model(input logic [7:0] b);
    logic [9:0] f;
    int v;
    int ones;
    v    = int'(b);
    ones = 0;
    f    = '0;
    for (int i = 0; i < 8; i++) begin
      f[i] = ((v >> i) % 2) == 1;
      ones += (v >> i) % 2;
    end
    f[8] = (ones % 2) == 0;
    f[9] = 1'b1;
    return f;
  endfunction

  // driver + device model for one transfer
  task automatic run_frame(input logic [7:0] b, input int mode, input bit keep,
                           input logic [7:0] alt, input int exp_inh,
                           input bit exp_done, input bit exp_err);
    int d0, e0, w, inh, stp, n_edges, c_fall;
    logic [9:0] line;
    logic [9:0] exp_line;
    line    = '0;
    c_fall  = 0;
    n_edges = (mode == M_TIMEOUT) ? 4 : ((mode == M_RESET) ? 5 : 11);
    @(negedge clk);
    d0 = done_cnt;
    e0 = err_cnt;
    tx_data  = b;
    tx_valid = 1'b1;
    w = 0;
    while (!ps2_clk_oe && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("accepted", 32'(ps2_clk_oe), 32'd1);
    check("busy_ready", 32'({busy, tx_ready}), 32'b10);
    if (keep) tx_data = alt;
    else tx_valid = 1'b0;
    inh = 0;
    while (ps2_clk_oe && !ps2_dat_oe && inh < 4 * INH) begin
      inh++;
      @(negedge clk);
    end
    check("inhibit_len", 32'(inh), 32'(exp_inh));
    stp = 0;
    while (ps2_clk_oe && ps2_dat_oe && stp < 4 * STP) begin
      stp++;
      @(negedge clk);
    end
    check("setup_len", 32'(stp), 32'(STP));
    check("start_bit_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b01);
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= n_edges; k++) begin
      if (k == n_edges) c_fall = cyc;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (k <= 10) line[k-1] = ps2_dat_in;
      dev_clk = 1'b1;
      if (k == 10 && mode == M_ACK) dev_dat = 1'b0;
      if (k == 11) dev_dat = 1'b1;
      if (k < n_edges) repeat (HALF) @(negedge clk);
    end
    if (mode == M_RESET) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      check("abort_ready", 32'({tx_ready, busy}), 32'b10);
      repeat (5) @(negedge clk);
      @(posedge clk);
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);
      check("abort_no_error", 32'(err_cnt - e0), 32'd0);
    end else begin
      w = 0;
      while (done_cnt + err_cnt == d0 + e0 && w < TMO + 100) begin
        @(posedge clk);
        w++;
      end
      check("terminated", 32'(done_cnt + err_cnt != d0 + e0), 32'd1);
      @(posedge clk);
      check("done_pulses", 32'(done_cnt - d0), 32'(exp_done));
      check("error_pulses", 32'(err_cnt - e0), 32'(exp_err));
      check("end_oe", 32'(end_oe), 32'd0);
      check("end_ready", 32'(end_ready), 32'd1);
      if (mode == M_TIMEOUT) begin
        // two synchronizer flops plus the edge-detect stage sit before the counter
        check("timeout_latency", 32'(end_cyc - c_fall), 32'(TMO + 3));
      end else begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          exp_line = exp_q.pop_front();
          check("frame_bits", 32'(line), 32'(exp_line));
        end
      end
    end
  endtask

  initial begin
    vecs[0] = '{data: 8'hF4, mode: M_ACK,  line: 10'h2F4, done: 1'b1, err: 1'b0};
    vecs[1] = '{data: 8'h00, mode: M_ACK,  line: 10'h300, done: 1'b1, err: 1'b0};
    vecs[2] = '{data: 8'hFF, mode: M_ACK,  line: 10'h3FF, done: 1'b1, err: 1'b0};
    vecs[3] = '{data: 8'h01, mode: M_NACK, line: 10'h201, done: 1'b0, err: 1'b1};
    vecs[4] = '{data: 8'hA5, mode: M_NACK, line: 10'h3A5, done: 1'b0, err: 1'b1};
    vecs[5] = '{data: 8'h80, mode: M_ACK,  line: 10'h280, done: 1'b1, err: 1'b0};

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_ready_busy", 32'({tx_ready, busy}), 32'b10);
    check("reset_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    check("reset_pulses", 32'({tx_done, tx_error}), 32'd0);

    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vecs[i].line);
      run_frame(vecs[i].data, vecs[i].mode, 1'b0, 8'h00, INH, vecs[i].done, vecs[i].err);
    end

    for (int i = 0; i < 6; i++) begin
      logic [7:0] rb;
      int rm;
      rb = 8'($urandom_range(0, 255));
      rm = int'($urandom_range(0, 1));
      exp_q.push_back(frame_model(rb));
      run_frame(rb, rm, 1'b0, 8'h00, INH, rm == M_ACK, rm == M_NACK);
    end

    // device stalls after four falls
    run_frame(8'h5A, M_TIMEOUT, 1'b0, 8'h00, INH, 1'b0, 1'b1);

    // reset during bit 5, then a clean 0xED (parity 1)
    run_frame(8'hC7, M_RESET, 1'b0, 8'h00, INH, 1'b0, 1'b0);
    exp_q.push_back(10'h3ED);
    run_frame(8'hED, M_ACK, 1'b0, 8'h00, INH, 1'b1, 1'b0);

    // tx_valid held with a new byte during the transfer; the second byte is
    // taken on the edge after the first completes, one cycle before we look
    exp_q.push_back(10'h33C);
    run_frame(8'h3C, M_ACK, 1'b1, 8'hC3, INH, 1'b1, 1'b0);
    exp_q.push_back(10'h3C3);
    run_frame(8'hC3, M_ACK, 1'b0, 8'h00, INH - 1, 1'b1, 1'b0);

    repeat (5) @(negedge clk);
    check("done_error_overlap", 32'(overlap), 32'd0);
    check("idle_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
